// File: rtl/x_dll_lock_sequencer_pkg.sv
// x_dll_pkg: shared state encodings and width helpers for the DLL lock sequencer.
package x_dll_pkg;
  typedef enum logic [2:0] {
    RESET_DLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } state_e;
  localparam int LOSS_CNT_W = 8;
  function automatic int clog2w(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction
endpackage

// File: rtl/x_dll_lock_sequencer_if.sv
// x_dll_lock_sequencer_if: DLL lock/reset signal bundle between the sequencer and its environment.
interface x_dll_lock_sequencer_if
  import x_dll_pkg::*;
#(
  parameter int RETRY_W = 3
) ();
  logic                  locked;
  logic                  relock_req;
  logic                  dll_rst;
  logic                  sys_rst_n;
  logic                  ready;
  logic                  error;
  logic [RETRY_W-1:0]    retry_cnt;
  logic [LOSS_CNT_W-1:0] loss_cnt;
  logic [2:0]            state;
  modport master (
    input  locked, relock_req,
    output dll_rst, sys_rst_n, ready, error, retry_cnt, loss_cnt, state
  );
  modport slave (
    output locked, relock_req,
    input  dll_rst, sys_rst_n, ready, error, retry_cnt, loss_cnt, state
  );
endinterface

// File: rtl/x_dll_lock_sequencer_sync2.sv
// x_sync2: two-flop synchronizer with asynchronous active-low reset to 0.
module x_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic [1:0] sync_q, sync_d;
  always_comb sync_d = {sync_q[0], d};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sync_q <= 2'b00;
    else sync_q <= sync_d;
  assign q = sync_q[1];
endmodule

// File: rtl/x_dll_lock_sequencer.sv
// x_dll_lock_sequencer: pulses DLL reset, waits for a stable lock with timeout/retry, then releases system reset.
module x_dll_lock_sequencer
  import x_dll_pkg::*;
#(
  parameter int RST_PULSE_CYCLES = 3,
  parameter int LOCK_TIMEOUT     = 1024,
  parameter int STABLE_CYCLES    = 16,
  parameter int MAX_RETRIES      = 4
) (
  input logic clk,
  input logic rst_n,
  x_dll_lock_sequencer_if.master bus
);
  localparam int CNT_MAX = (LOCK_TIMEOUT > STABLE_CYCLES)
                         ? ((LOCK_TIMEOUT > RST_PULSE_CYCLES) ? LOCK_TIMEOUT : RST_PULSE_CYCLES)
                         : ((STABLE_CYCLES > RST_PULSE_CYCLES) ? STABLE_CYCLES : RST_PULSE_CYCLES);
  localparam int CNT_W   = clog2w(CNT_MAX);
  localparam int RETRY_W = clog2w(MAX_RETRIES + 1);
  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [RETRY_W-1:0]    retry_q, retry_d;
  logic [LOSS_CNT_W-1:0] loss_q, loss_d;
  logic                  dll_rst_q, dll_rst_d, run_q, run_d, error_q, error_d;
  logic                  locked_s;
  x_sync2 u_lock_sync (.clk(clk), .rst_n(rst_n), .d(bus.locked), .q(locked_s));
  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    loss_d  = loss_q;
    case (state_q)
      RESET_DLL: if (cnt_q == CNT_W'(RST_PULSE_CYCLES - 1)) state_d = WAIT_LOCK;
      WAIT_LOCK:
        if (locked_s) state_d = STABLE;
        else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
          retry_d = retry_q + 1'b1;
          state_d = (retry_d == RETRY_W'(MAX_RETRIES)) ? FAIL : RESET_DLL;
        end
      STABLE:
        if (!locked_s) state_d = WAIT_LOCK;
        else if (cnt_q == CNT_W'(STABLE_CYCLES - 1)) begin
          state_d = RUN;
          retry_d = '0;
        end
      RUN:
        if (!locked_s || bus.relock_req) begin
          state_d = RESET_DLL;
          loss_d  = (&loss_q) ? loss_q : loss_q + 1'b1;
        end
      default: state_d = FAIL;
    endcase
    // The shared counter restarts on every transition and idles in RUN/FAIL.
    cnt_d     = (state_d != state_q || state_q == RUN || state_q == FAIL) ? '0 : cnt_q + 1'b1;
    dll_rst_d = (state_d == RESET_DLL) || (state_d == FAIL);
    run_d     = state_d == RUN;
    error_d   = state_d == FAIL;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q   <= RESET_DLL;
      cnt_q     <= '0;
      retry_q   <= '0;
      loss_q    <= '0;
      dll_rst_q <= 1'b1;
      run_q     <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      loss_q    <= loss_d;
      dll_rst_q <= dll_rst_d;
      run_q     <= run_d;
      error_q   <= error_d;
    end
  assign bus.dll_rst   = dll_rst_q;
  assign bus.sys_rst_n = run_q;
  assign bus.ready     = run_q;
  assign bus.error     = error_q;
  assign bus.retry_cnt = retry_q;
  assign bus.loss_cnt  = loss_q;
  assign bus.state     = state_q;
endmodule
